// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive-side byte queue between a UART receiver and a consumer.
//
// The receiver is never stalled (in_ready is tied high). When the queue is full and
// nothing is popped in the same cycle, the incoming byte is dropped and counted.
// The read side is first-word-fall-through: out_data shows the head entry whenever
// out_valid is high.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid=1 and ready=1.
//   Push side: in_ready is always 1, so in_valid=1 alone is a push. A push that
//   arrives while full with no pop is dropped; overrun and drop_count record it.
//   Pop side: out_valid=1 and out_ready=1 is a pop. While out_valid=1 and no pop
//   happens, out_data stays stable.
//
// Optional feature: define UART_RX_FIFO_IRQ_EN to get a registered interrupt
// irq = (level >= THRESHOLD) | overrun. Without that macro, irq is held at 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_data      byte from the receiver
//   in_valid     receiver byte valid
//   in_ready     accept strobe to the receiver (constant 1)
//   out_data     head-of-queue byte (reads as 0 while empty)
//   out_valid    queue non-empty
//   out_ready    consumer pop request
//   flush        synchronous queue clear (takes priority over push/pop)
//   level        occupancy 0..DEPTH
//   overrun      sticky "a byte was dropped" flag
//   overrun_clr  clears overrun and drop_count
//   drop_count   saturating count of dropped bytes
//   irq          service request
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_BITS-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [7:0]                 drop_count,
  output logic                       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [AW:0]          level_q;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic pop_ok;
  logic drop;

  assign in_ready = 1'b1;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);
  assign pop   = ~empty & out_ready;

  // A pop in the same cycle frees the slot, so a push into a full queue is
  // only dropped when no pop goes with it. Flush cancels both directions.
  assign push_ok = in_valid & (~full | pop) & ~flush;
  assign pop_ok  = pop & ~flush;
  assign drop    = in_valid & full & ~pop & ~flush;

  // Storage is deliberately unreset; it is never visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      level_q <= '0;
    end else if (flush) begin
      head    <= tail;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + AW'(1);
      end
      if (pop_ok) begin
        head <= head + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A clear that coincides with a drop leaves that one drop recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (overrun_clr) begin
      overrun    <= drop;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign level     = level_q;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[head];

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [AW:0] IRQ_LEVEL = (AW+1)'(THRESHOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (level_q >= IRQ_LEVEL) | overrun;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed self-checking bench for uart_rx_fifo (DEPTH=16,
// THRESHOLD=8). Inputs change 1 ns after a rising edge, and outputs are sampled there too.
module tb_uart_rx_fifo;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [4:0]   level;
  logic         overrun;
  logic         overrun_clr;
  logic [7:0]   drop_count;
  logic         irq;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESHOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .level       (level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .drop_count  (drop_count),
    .irq         (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [W-1:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(out_data), 32'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic expect_irq(input logic en_value);
`ifdef UART_RX_FIFO_IRQ_EN
    return en_value;
`else
    return 1'b0 & en_value;
`endif
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    flush = 1'b0; overrun_clr = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("in_ready_high", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Basic FWFT ordering.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    check("abc_level", 32'(level), 32'd3);
    check("abc_head", 32'(out_data), 32'h41);
    tick();
    check("abc_head_stable", 32'(out_data), 32'h41);
    for (int i = 0; i < 3; i++) pop_check("abc_read");
    check("abc_empty", 32'(out_valid), 32'd0);

    // Push while empty with out_ready already high: no pop that cycle.
    out_ready = 1'b1; in_data = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("wr_rd_level", 32'(level), 32'd1);
    check("wr_rd_valid", 32'(out_valid), 32'd1);
    check("wr_rd_data", 32'(out_data), 32'h77);
    tick();
    out_ready = 1'b0;
    check("wr_rd_drained", 32'(level), 32'd0);

    // Overfill: 18 pushes, the last two are dropped.
    for (int i = 0; i < 18; i++) begin
      push_byte(W'(i));
      if (i < 16) exp_q.push_back(W'(i));
    end
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_overrun", 32'(overrun), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_head", 32'(out_data), 32'h00);

    // Drop counter saturates at 255.
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    check("drop_saturate", 32'(drop_count), 32'd255);
    check("drop_level", 32'(level), 32'd16);

    // Clear coinciding with a drop keeps that drop.
    overrun_clr = 1'b1; in_valid = 1'b1; in_data = 8'hEF;
    tick();
    overrun_clr = 1'b0; in_valid = 1'b0;
    check("clr_drop_overrun", 32'(overrun), 32'd1);
    check("clr_drop_count", 32'(drop_count), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_count", 32'(drop_count), 32'd0);

    // Full queue, simultaneous push 0xAA and pop.
    check("full_pop_data", 32'(out_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'hAA);
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pp_level", 32'(level), 32'd16);
    check("full_pp_overrun", 32'(overrun), 32'd0);
    check("full_pp_drop", 32'(drop_count), 32'd0);
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    check("full_drain_empty", 32'(out_valid), 32'd0);

    // Mid-level push+pop leaves level unchanged.
    push_byte(8'h21); push_byte(8'h22);
    in_valid = 1'b1; in_data = 8'h23; out_ready = 1'b1;
    check("mid_pp_head", 32'(out_data), 32'h21);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("mid_pp_level", 32'(level), 32'd2);
    check("mid_pp_next", 32'(out_data), 32'h22);

    // Flush with a coincident push: 0x55 never appears.
    for (int i = 0; i < 3; i++) push_byte(8'h10 + W'(i));
    check("pre_flush_level", 32'(level), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    push_byte(8'h66);
    check("post_flush_level", 32'(level), 32'd1);
    check("post_flush_data", 32'(out_data), 32'h66);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Threshold interrupt.
    for (int i = 0; i < 7; i++) push_byte(8'h30 + W'(i));
    tick();
    check("irq_below", 32'(irq), 32'd0);
    push_byte(8'h37);
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_at_thr", 32'(irq), 32'(expect_irq(1'b1)));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("irq_pop_level", 32'(level), 32'd7);
    tick();
    check("irq_after_pop", 32'(irq), 32'd0);

    // Asynchronous reset between edges.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h90 + W'(i));
    check("pre_rst_level", 32'(level), 32'd4);
    #2 rst = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b1;
    push_byte(8'hC3);
    check("post_rst_level", 32'(level), 32'd1);
    check("post_rst_data", 32'(out_data), 32'hC3);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, byte width matching the upstream receiver.
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of two and at least 2.
REQ-003 SHALL have parameter THRESHOLD, default 8, irq level threshold in the range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_data, input, DATA_BITS, byte from the receiver.
REQ-007 SHALL have port in_valid, input, 1, receiver byte valid.
REQ-008 SHALL have port in_ready, output, 1, accept strobe to the receiver.
REQ-009 SHALL have port out_data, output, DATA_BITS, head-of-queue byte.
REQ-010 SHALL have port out_valid, output, 1, queue non-empty.
REQ-011 SHALL have port out_ready, input, 1, consumer pop request.
REQ-012 SHALL have port flush, input, 1, synchronous queue clear.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1, occupancy 0..DEPTH.
REQ-014 SHALL have port overrun, output, 1, sticky byte-dropped flag.
REQ-015 SHALL have port overrun_clr, input, 1, clears overrun.
REQ-016 SHALL have port drop_count, output, 8, saturating count of dropped bytes.
REQ-017 SHALL have port irq, output, 1, service request.

Function
REQ-018 SHALL tie in_ready to 1 permanently, so the receiver is never stalled and returns to idle within one cycle of presenting a byte.
REQ-019 SHALL define a push as in_valid=1 at a rising clk edge.
REQ-020 SHALL write a push into the tail entry when not full and increment level.
REQ-021 SHALL discard a push when full with no pop that cycle, set overrun, and increment drop_count, saturating at 255.
REQ-022 SHALL behave first-word-fall-through: out_valid = (level != 0), and out_data = the head entry combinationally from storage.
REQ-023 SHALL define a pop as out_valid=1 and out_ready=1 at a rising clk edge; a pop advances the head and decrements level.
REQ-024 SHALL on a simultaneous push and pop when full accept both, with level staying DEPTH, no overrun and no drop.
REQ-025 SHALL on a push while empty with out_ready=1 perform no pop, set level to 1, and assert out_valid the next cycle (1-cycle write-to-read latency).
REQ-026 SHALL on a simultaneous push and pop when neither full nor empty leave level unchanged.
REQ-027 SHALL wrap head and tail pointers modulo DEPTH, with the full/empty distinction held in the extra level bit.
REQ-028 SHALL on flush=1 set level to 0 and equalise the pointers next cycle; any push or pop in the same cycle is ignored; overrun and drop_count are unaffected.
REQ-029 SHALL clear overrun and zero drop_count on overrun_clr=1; when it coincides with a drop, overrun ends at 1 and drop_count at 1.
REQ-030 SHALL not change out_data while out_valid=1 and no pop occurs.

Reset
REQ-031 SHALL on rst=0, immediately and independent of clk, force level=0, out_valid=0, overrun=0, drop_count=0, irq=0 and both pointers=0.
REQ-032 SHALL leave storage contents unreset and never expose them while empty.
REQ-033 SHALL, when reset is asserted mid-stream, lose all queued bytes and accept the first push one cycle after rst deasserts.

Configuration
REQ-034 SHALL with macro UART_RX_FIFO_IRQ_EN defined register irq = (level >= THRESHOLD) | overrun, updated one cycle after level or overrun changes.
REQ-035 SHALL without UART_RX_FIFO_IRQ_EN keep the irq port and drive it constant 0, with no threshold comparator synthesised.

Verification
REQ-036 SHALL cover: after reset, push 0x41, 0x42, 0x43 with out_ready=0 -> level=3, out_data=0x41; then hold out_ready=1 -> reads 0x41, 0x42, 0x43, then out_valid=0.
REQ-037 SHALL cover: DEPTH=16, push 18 bytes 0x00..0x11 without pops -> level=16, overrun=1, drop_count=2; pops read 0x00..0x0F.
REQ-038 SHALL cover: full queue with push 0xAA and pop in the same cycle -> level stays 16, overrun=0, 0xAA read last.
REQ-039 SHALL cover: 5 entries queued, flush together with push 0x55 -> level=0 and out_valid=0 next cycle; 0x55 is never read.
REQ-040 SHALL cover: IRQ_EN defined, THRESHOLD=8, push 7 bytes -> irq=0; 8th byte -> irq=1 one cycle later; one pop -> irq=0.
REQ-041 SHALL cover: rst asserted asynchronously between clk edges with level=4 -> out_valid=0 and level=0 before the next edge.
